// File: rtl/ysyx_22040365_ifu.sv
// ysyx_22040365_ifu -- instruction fetch unit.
//
// This unit fetches one instruction at a time from instruction memory and
// presents it to the decode stage. No more than one memory request is
// outstanding at any time. Redirects from execute replace the fetch pc. A
// response that is still in flight when a redirect arrives is discarded
// through the kill flag. A fetch fault, either an access error or a
// misaligned redirect target, is presented once as a NOP marked with
// id_fault. The unit then halts until the next redirect or reset.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   imem_req_valid/ready     request handshake; imem_req_addr is the address
//   imem_rsp_valid/data/err  response; used only while waiting for it
//   redirect_valid/pc        control-flow redirect from execute
//   id_valid/ready           decode handshake; id_inst/id_pc/id_fault payload
//   dbg_state                current FSM state (REQ=0, WAIT=1, HOLD=2, HALT=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The payload holds steady while valid=1 and ready=0. The only
// exception is a redirect, which may change the request address.
module ysyx_22040365_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    output logic        id_fault,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [63:0] pc;
    logic        kill;   // the in-flight response belongs to a stale pc

    // The rst term keeps the request low during every reset cycle. It stays
    // low even before the first reset edge has forced the state to REQ.
    assign imem_req_valid = rst && (state == S_REQ);
    assign imem_req_addr  = pc;
    assign id_valid       = (state == S_HOLD);
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            id_inst  <= NOP;
            id_pc    <= RESET_PC;
            id_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                // Misaligned target: fault straight to decode, no request.
                state    <= S_HOLD;
                kill     <= 1'b0;
                id_inst  <= NOP;
                id_pc    <= redirect_pc;
                id_fault <= 1'b1;
            end else begin
                case (state)
                    S_REQ: begin
                        // If this cycle's request is accepted, its response is stale.
                        kill  <= imem_req_ready;
                        state <= imem_req_ready ? S_WAIT : S_REQ;
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            // The stale response lands in this same cycle; drop it now.
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end
                    default: begin
                        // Drop the held instruction, or leave HALT.
                        kill  <= 1'b0;
                        state <= S_REQ;
                    end
                endcase
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            id_inst  <= imem_rsp_err ? NOP : imem_rsp_data;
                            id_pc    <= pc;
                            id_fault <= imem_rsp_err;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        if (id_fault) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 64'd4;
                            state <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed testbench for ysyx_22040365_ifu.
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit after that, so the checks fall between active edges.
module tb_ysyx_22040365_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        id_fault;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    ysyx_22040365_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_fault       (id_fault),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the id-side outputs together.
    task automatic chk_id(input string tag, input logic v, input logic [31:0] inst,
                          input logic [63:0] pc, input logic f);
        chk({tag, ".id_valid"}, {63'd0, id_valid}, {63'd0, v});
        chk({tag, ".id_inst"}, {32'd0, id_inst}, {32'd0, inst});
        chk({tag, ".id_pc"}, id_pc, pc);
        chk({tag, ".id_fault"}, {63'd0, id_fault}, {63'd0, f});
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [63:0] addr);
        chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, {63'd0, v});
        if (v) chk({tag, ".req_addr"}, imem_req_addr, addr);
    endtask

    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b0;

        // Reset state.
        tick(); tick(); tick();
        #1;
        chk_req("reset", 1'b0, 64'h0);
        chk_id("reset", 1'b0, 32'h0000_0013, 64'h8000_0000, 1'b0);

        // First fetch with zero-wait memory.
        rst = 1'b1; imem_req_ready = 1'b1;
        #1;
        chk_req("first_req", 1'b1, 64'h8000_0000);
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        #1;
        chk_req("wait_no_req", 1'b0, 64'h0);
        chk_id("wait_no_id", 1'b0, 32'h0000_0013, 64'h8000_0000, 1'b0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk_id("first_hold", 1'b1, 32'h0010_0093, 64'h8000_0000, 1'b0);

        // Decode stalls for 5 cycles. A stray response in HOLD must be ignored.
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFFFF_FFFF; imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_id("stall", 1'b1, 32'h0010_0093, 64'h8000_0000, 1'b0);
            chk_req("stall", 1'b0, 64'h0);
        end
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        chk_id("after_consume", 1'b0, 32'h0010_0093, 64'h8000_0000, 1'b0);
        chk_req("next_pc", 1'b1, 64'h8000_0004);

        // The request address stays stable while memory is not ready.
        tick(); tick();
        chk_req("req_stable", 1'b1, 64'h8000_0004);

        // Normal fetch at 0x80000004.
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113; tick();
        imem_rsp_valid = 1'b0;
        chk_id("second", 1'b1, 32'h0020_0113, 64'h8000_0004, 1'b0);
        id_ready = 1'b1; tick(); id_ready = 1'b0;

        // An access fault at 0x80000008 yields a NOP with id_fault, then halts.
        #1;
        chk_req("third_req", 1'b1, 64'h8000_0008);
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1;
        imem_rsp_data = 32'h1234_5678; tick();
        imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
        chk_id("err", 1'b1, 32'h0000_0013, 64'h8000_0008, 1'b1);
        id_ready = 1'b1; tick(); id_ready = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_req("halt", 1'b0, 64'h0);
            chk("halt.id_valid", {63'd0, id_valid}, 64'd0);
            tick();
        end
        imem_req_ready = 1'b0;

        // A misaligned redirect faults without issuing a request.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; tick();
        redirect_valid = 1'b0;
        #1;
        chk_req("misalign", 1'b0, 64'h0);
        chk_id("misalign", 1'b1, 32'h0000_0013, 64'h8000_0102, 1'b1);
        // A redirect in HOLD drops the held instruction and resumes fetch.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; tick();
        redirect_valid = 1'b0;
        #1;
        chk("resume.id_valid", {63'd0, id_valid}, 64'd0);
        chk_req("resume", 1'b1, 64'h8000_0200);

        // A redirect in WAIT kills the response that arrives next cycle.
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; tick();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("kill.id_valid", {63'd0, id_valid}, 64'd0);
        chk_req("kill", 1'b1, 64'h8000_0100);

        // A redirect and a response in the same WAIT cycle.
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_AAAA; tick();
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk("same.id_valid", {63'd0, id_valid}, 64'd0);
        chk_req("same", 1'b1, 64'h8000_0300);

        // A redirect in REQ without ready changes the address next cycle.
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0400; tick();
        redirect_valid = 1'b0;
        #1;
        chk_req("req_redirect", 1'b1, 64'h8000_0400);

        // A redirect in REQ with ready kills the accepted request.
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0500; tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_5555; tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("req_kill.id_valid", {63'd0, id_valid}, 64'd0);
        chk_req("req_kill", 1'b1, 64'h8000_0500);

        // The pc increment wraps modulo 2^64.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; tick();
        imem_rsp_valid = 1'b0;
        chk_id("wrap", 1'b1, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        id_ready = 1'b1; tick(); id_ready = 1'b0;
        #1;
        chk_req("wrap_next", 1'b1, 64'h0);

        // Reset during WAIT. A response arriving during reset is ignored.
        imem_req_ready = 1'b1; tick();
        imem_req_ready = 1'b0; rst = 1'b0; tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD;
        #1;
        chk_req("in_reset", 1'b0, 64'h0);
        tick();
        imem_rsp_valid = 1'b0;
        chk_id("in_reset", 1'b0, 32'h0000_0013, 64'h8000_0000, 1'b0);
        rst = 1'b1;
        #1;
        chk_req("post_reset", 1'b1, 64'h8000_0000);
        // A late response in REQ after reset is also ignored.
        imem_rsp_valid = 1'b1; tick();
        imem_rsp_valid = 1'b0;
        chk("late.id_valid", {63'd0, id_valid}, 64'd0);
        chk_req("late", 1'b1, 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040365_ifu.md
YSYX_22040365_IFU -- requirements
Module: ysyx_22040365_ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  64  fetch address, word-aligned.
REQ-007 imem_rsp_valid  input  1  instruction word returned this cycle.
REQ-008 imem_rsp_data  input  32  instruction word.
REQ-009 imem_rsp_err  input  1  access fault on returned word; qualified by imem_rsp_valid.
REQ-010 redirect_valid  input  1  control-flow redirect from execute stage.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 id_valid  output  1  instruction presented to decode stage.
REQ-013 id_ready  input  1  decode stage consumes instruction this cycle.
REQ-014 id_inst  output  32  instruction to decode (drives decode inst input).
REQ-015 id_pc  output  64  address of id_inst.
REQ-016 id_fault  output  1  id_inst is invalid; fetch fault (access or misaligned).

Function
REQ-017 The block SHALL hold a 64-bit pc register and a 4-state FSM: REQ, WAIT, HOLD, HALT.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT, otherwise stay REQ.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid, capture data into id_inst, pc into id_pc, err into id_fault -> HOLD.
REQ-020 HOLD: id_valid=1; on id_ready with id_fault=0, pc<=pc+4 (mod 2^64) -> REQ; on id_ready with id_fault=1 -> HALT.
REQ-021 HALT: no requests, id_valid=0; leaves only on reset or redirect.
REQ-022 At most one request SHALL be outstanding; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-023 id_inst, id_pc, id_fault SHALL remain stable while id_valid=1 and id_ready=0.
REQ-024 imem_req_addr SHALL remain stable while imem_req_valid=1 and imem_req_ready=0, except when a redirect occurs.
REQ-025 Redirect in REQ without imem_req_ready: pc<=redirect_pc, stay REQ; new address appears next cycle.
REQ-026 Redirect in REQ with imem_req_ready, or in WAIT: set kill flag, pc<=redirect_pc; the pending response SHALL be discarded (no HOLD), then -> REQ.
REQ-027 Redirect and imem_rsp_valid in the same WAIT cycle: response discarded, -> REQ with redirect_pc.
REQ-028 Redirect in HOLD (with or without id_ready): held instruction dropped, id_valid=0 next cycle, pc<=redirect_pc -> REQ.
REQ-029 Redirect in HALT: pc<=redirect_pc -> REQ.
REQ-030 redirect_pc[1:0]!=0: no memory request; -> HOLD with id_inst=32'h0000_0013, id_pc=redirect_pc, id_fault=1.
REQ-031 Zero-wait memory (ready=1, rsp one cycle after accept) SHALL give id_valid two cycles after request issue; best throughput one instruction per 3 cycles.
REQ-032 A fault instruction SHALL always carry id_inst=32'h0000_0013 (NOP) regardless of imem_rsp_data.

Reset
REQ-033 While rst=0 at a clock edge: state<=REQ, pc<=RESET_PC, kill<=0, id_valid=0, id_inst<=32'h0000_0013, id_pc<=RESET_PC, id_fault<=0.
REQ-034 imem_req_valid SHALL be 0 in any cycle in which rst=0; first request at RESET_PC in the first cycle after rst returns to 1.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request; a late response after reset SHALL be ignored.

Verification
REQ-036 Reset release, ready=1, rsp next cycle data 32'h00100093 -> addr 0x80000000, id_valid with id_inst 0x00100093, id_pc 0x80000000; after id_ready next addr 0x80000004.
REQ-037 id_ready held 0 for 5 cycles in HOLD -> id outputs constant, no new imem request; release -> addr 0x80000004.
REQ-038 Redirect to 0x80000100 in WAIT, response 0xDEADBEEF arrives next cycle -> response dropped, no id_valid, next request addr 0x80000100.
REQ-039 imem_rsp_err=1 at pc 0x80000008 -> id_valid, id_fault=1, id_inst 0x00000013; after id_ready no further requests until redirect.
REQ-040 Redirect to 0x80000102 -> no request, id_fault=1, id_pc 0x80000102; redirect to 0x80000200 then resumes fetch there.
REQ-041 rst=0 asserted in WAIT, response arrives during reset -> ignored, first post-reset request addr 0x80000000.
